// File: rtl/gmii_pkg.sv
// Shared GMII receive-path definitions: framing bytes, CRC-32 constants,
// byte-counter width and the framer state encoding.
package gmii_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704_DD7B;
    // IEEE 802.3 generator polynomial, MSB-first register orientation
    localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;

    localparam int unsigned LEN_W        = 14;
    localparam int unsigned FCS_BYTES    = 4;
    // Shortest frame that emits at least one payload byte
    localparam int unsigned MIN_EVAL_LEN = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_DISCARD
    } framer_state_e;

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 (IEEE 802.3) update for one byte.
// The register is kept MSB-first while data bits enter LSB-first, which is the
// bit-reversed image of the usual reflected software CRC; the check residue
// in this orientation is CRC_RESIDUE.
// Ports:
//   crc        in  32  current CRC register
//   data       in  8   byte to absorb (bit 0 first on the wire)
//   crc_next_c out 32  updated CRC register (combinational)
module crc32_d8
    import gmii_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next_c
);

    logic [31:0] c_v;

    // Bit-serial LFSR unrolled over the 8 data bits
    always_comb begin
        c_v = crc;
        for (int i = 0; i < 8; i++) begin
            if (c_v[31] ^ data[i]) begin
                c_v = {c_v[30:0], 1'b0} ^ CRC_POLY;
            end else begin
                c_v = {c_v[30:0], 1'b0};
            end
        end
        crc_next_c = c_v;
    end

endmodule

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD/FCS, checks CRC-32 and length,
// and emits payload as one contiguous burst followed by a single status pulse.
// Ports:
//   clk125, reset               125 MHz GMII RX clock, async active-high reset
//   gmii_rxd/rx_dv/rx_er        GMII receive pins
//   rx_data, rx_data_valid      payload byte stream (FCS removed)
//   rx_good_frame, rx_bad_frame end-of-frame verdict pulses
//   stat_crc_err, stat_len_err  error cause, coincident with rx_bad_frame
//   stat_drop                   silently discarded frame
module gmii_rx_framer
    import gmii_pkg::*;
#(
    parameter int unsigned MIN_FRAME_LEN = 64,
    parameter int unsigned MAX_FRAME_LEN = 1518
) (
    input  logic       clk125,
    input  logic       reset,
    input  logic [7:0] gmii_rxd,
    input  logic       gmii_rx_dv,
    input  logic       gmii_rx_er,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    output logic       rx_good_frame,
    output logic       rx_bad_frame,
    output logic       stat_crc_err,
    output logic       stat_len_err,
    output logic       stat_drop
);

    localparam logic [LEN_W-1:0] LEN_SAT = '1;

    // Input stage
    logic [7:0] rxd_q;
    logic       dv_q;
    logic       er_q;
    logic       dv_prev_q;

    // Framer state and datapath
    framer_state_e               state_q, state_d;
    logic [31:0]                 crc_q, crc_d, crc_upd_c;
    logic [LEN_W-1:0]            len_q, len_d;
    logic                        err_q, err_d;
    logic [FCS_BYTES-1:0][7:0]   dline_q, dline_d;

    // Next values of the registered outputs
    logic [7:0] rx_data_d;
    logic       valid_d, good_d, bad_d, crc_err_d, len_err_d, drop_d;

    logic       crc_bad, len_bad;

    crc32_d8 u_crc (
        .crc        (crc_q),
        .data       (rxd_q),
        .crc_next_c (crc_upd_c)
    );

    // dv history resets high so a frame already in flight at reset release
    // is not mistaken for a rising edge
    always_ff @(posedge clk125 or posedge reset) begin
        if (reset) begin
            rxd_q     <= '0;
            dv_q      <= 1'b1;
            er_q      <= 1'b0;
            dv_prev_q <= 1'b1;
        end else begin
            rxd_q     <= gmii_rxd;
            dv_q      <= gmii_rx_dv;
            er_q      <= gmii_rx_er;
            dv_prev_q <= dv_q;
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk125 or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            crc_q         <= CRC_INIT;
            len_q         <= '0;
            err_q         <= 1'b0;
            dline_q       <= '0;
            rx_data       <= '0;
            rx_data_valid <= 1'b0;
            rx_good_frame <= 1'b0;
            rx_bad_frame  <= 1'b0;
            stat_crc_err  <= 1'b0;
            stat_len_err  <= 1'b0;
            stat_drop     <= 1'b0;
        end else begin
            state_q       <= state_d;
            crc_q         <= crc_d;
            len_q         <= len_d;
            err_q         <= err_d;
            dline_q       <= dline_d;
            rx_data       <= rx_data_d;
            rx_data_valid <= valid_d;
            rx_good_frame <= good_d;
            rx_bad_frame  <= bad_d;
            stat_crc_err  <= crc_err_d;
            stat_len_err  <= len_err_d;
            stat_drop     <= drop_d;
        end
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        len_d     = len_q;
        err_d     = err_q;
        dline_d   = dline_q;
        rx_data_d = rx_data;
        valid_d   = 1'b0;
        good_d    = 1'b0;
        bad_d     = 1'b0;
        crc_err_d = 1'b0;
        len_err_d = 1'b0;
        drop_d    = 1'b0;

        crc_bad = (crc_q != CRC_RESIDUE);
        len_bad = (32'(len_q) < MIN_FRAME_LEN) || (32'(len_q) > MAX_FRAME_LEN);

        unique case (state_q)
            ST_IDLE: begin
                if (dv_q) begin
                    if (!dv_prev_q && (rxd_q == PREAMBLE_BYTE)) begin
                        state_d = ST_PREAMBLE;
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end
            end

            ST_PREAMBLE: begin
                if (!dv_q) begin
                    state_d = ST_IDLE;
                    drop_d  = 1'b1;
                end else if (rxd_q == SFD_BYTE) begin
                    state_d = ST_DATA;
                    crc_d   = CRC_INIT;
                    len_d   = '0;
                    err_d   = 1'b0;
                end else if (rxd_q != PREAMBLE_BYTE) begin
                    state_d = ST_DISCARD;
                    drop_d  = 1'b1;
                end
            end

            ST_DATA: begin
                if (dv_q) begin
                    crc_d   = crc_upd_c;
                    len_d   = (len_q == LEN_SAT) ? len_q : len_q + LEN_W'(1);
                    dline_d = {dline_q[FCS_BYTES-2:0], rxd_q};
                    if (er_q) begin
                        err_d = 1'b1;
                    end
                    // Oldest byte leaves only once the line holds four bytes,
                    // so the trailing FCS is never emitted
                    if (len_q >= LEN_W'(FCS_BYTES)) begin
                        rx_data_d = dline_q[FCS_BYTES-1];
                        valid_d   = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                    if (len_q < LEN_W'(MIN_EVAL_LEN)) begin
                        drop_d = 1'b1;
                    end else if (crc_bad || err_q || len_bad) begin
                        bad_d     = 1'b1;
                        crc_err_d = crc_bad;
                        len_err_d = len_bad;
                    end else begin
                        good_d = 1'b1;
                    end
                end
            end

            ST_DISCARD: begin
                if (!dv_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Directed bench for gmii_rx_framer: builds frames with a reference CRC,
// drives them on the GMII pins and checks payload, latency and status pulses.
module tb_gmii_rx_framer;

    logic       clk125 = 1'b0;
    logic       reset;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv;
    logic       gmii_rx_er;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_good_frame;
    logic       rx_bad_frame;
    logic       stat_crc_err;
    logic       stat_len_err;
    logic       stat_drop;

    gmii_rx_framer #(
        .MIN_FRAME_LEN (64),
        .MAX_FRAME_LEN (1518)
    ) dut (
        .clk125        (clk125),
        .reset         (reset),
        .gmii_rxd      (gmii_rxd),
        .gmii_rx_dv    (gmii_rx_dv),
        .gmii_rx_er    (gmii_rx_er),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_good_frame (rx_good_frame),
        .rx_bad_frame  (rx_bad_frame),
        .stat_crc_err  (stat_crc_err),
        .stat_len_err  (stat_len_err),
        .stat_drop     (stat_drop)
    );

    always #4 clk125 = ~clk125;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk125) cyc <= cyc + 1;

    // Per-test observations
    int n_valid, n_good, n_bad, n_crc, n_len, n_drop, n_stray;
    int first_cyc, last_cyc, stat_cyc, first_drive;
    logic [7:0] obs  [$];
    logic [7:0] sent [$];
    logic [7:0] frm  [$];

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Output monitor, sampled 1 time unit after the active edge
    always @(posedge clk125) begin
        #1;
        if (!reset) begin
            if (rx_data_valid) begin
                obs.push_back(rx_data);
                if (n_valid == 0) first_cyc = cyc;
                last_cyc = cyc;
                n_valid++;
            end
            if (rx_good_frame) n_good++;
            if (rx_bad_frame)  n_bad++;
            if (stat_crc_err)  n_crc++;
            if (stat_len_err)  n_len++;
            if (stat_drop)     n_drop++;
            if (rx_good_frame || rx_bad_frame || stat_drop) stat_cyc = cyc;
            if ((stat_crc_err || stat_len_err) && !rx_bad_frame) n_stray++;
        end
    end

    task automatic clear_stats();
        n_valid = 0; n_good = 0; n_bad = 0; n_crc = 0; n_len = 0;
        n_drop = 0; n_stray = 0; first_cyc = -1; last_cyc = -1;
        stat_cyc = -1; first_drive = -1;
        obs.delete();
        sent.delete();
    endtask

    task automatic drive(input logic dv, input logic er, input logic [7:0] d);
        @(negedge clk125);
        gmii_rx_dv = dv;
        gmii_rx_er = er;
        gmii_rxd   = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
    endtask

    // Standard reflected CRC-32 over frm, final inversion applied
    function automatic logic [31:0] fcs_of_frm();
        logic [31:0] c = 32'hFFFF_FFFF;
        foreach (frm[i]) begin
            c = c ^ {24'd0, frm[i]};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    task automatic build_frame(input int n_payload, input int seed, input bit with_fcs);
        logic [31:0] fcs;
        frm.delete();
        for (int i = 0; i < n_payload; i++) frm.push_back(8'(i * 7 + seed));
        if (with_fcs) begin
            fcs = fcs_of_frm();
            for (int k = 0; k < 4; k++) frm.push_back(fcs[8*k +: 8]);
        end
    endtask

    // Preamble + SFD + frm, optional rx_er/bit flip, then one dv-low cycle
    task automatic send_frame(input int n_pre, input int er_idx, input int flip_idx);
        logic [7:0] b;
        for (int i = 0; i < n_pre; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < frm.size(); i++) begin
            b = frm[i] ^ ((i == flip_idx) ? 8'h04 : 8'h00);
            drive(1'b1, (i == er_idx), b);
            if (i < frm.size() - 4) begin
                if (i == 0 && sent.size() == 0) first_drive = cyc;
                sent.push_back(b);
            end
        end
        drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic check_frame(input string name, input int nfr, input int exp_valid,
                               input int exp_good, input int exp_bad, input int exp_crc,
                               input int exp_len, input int exp_drop);
        int diffs = 0;
        idle(12);
        check({name, ".valid_cnt"}, n_valid, exp_valid);
        check({name, ".good"},      n_good,  exp_good);
        check({name, ".bad"},       n_bad,   exp_bad);
        check({name, ".crc_err"},   n_crc,   exp_crc);
        check({name, ".len_err"},   n_len,   exp_len);
        check({name, ".drop"},      n_drop,  exp_drop);
        check({name, ".stray_stat"}, n_stray, 0);
        if (exp_valid > 0) begin
            for (int i = 0; i < exp_valid; i++) begin
                if (i >= obs.size() || i >= sent.size() || obs[i] !== sent[i]) diffs++;
            end
            check({name, ".data_diffs"}, diffs, 0);
            check({name, ".status_cyc"}, stat_cyc, last_cyc + 1);
            if (nfr == 1) begin
                check({name, ".latency"},    first_cyc - first_drive, 6);
                check({name, ".contiguous"}, last_cyc - first_cyc + 1, exp_valid);
            end
        end
    endtask

    function automatic int outs_now();
        return 32'({rx_data, rx_data_valid, rx_good_frame, rx_bad_frame,
                    stat_crc_err, stat_len_err, stat_drop});
    endfunction

    initial begin
        reset      = 1'b1;
        gmii_rxd   = 8'h00;
        gmii_rx_dv = 1'b0;
        gmii_rx_er = 1'b0;
        clear_stats();
        repeat (3) @(negedge clk125);
        #1 check("reset.outs", outs_now(), 0);
        @(negedge clk125);
        reset = 1'b0;
        idle(4);

        //             name         nfr valid good bad crc len drop
        clear_stats(); build_frame(60, 3, 1);   send_frame(7, -1, -1);
        check_frame("good_L64",   1, 60,   1,   0,  0,  0,  0);

        clear_stats(); build_frame(60, 3, 1);   send_frame(7, -1, 10);
        check_frame("crc_flip",   1, 60,   0,   1,  1,  0,  0);

        clear_stats(); build_frame(60, 3, 1);   send_frame(7, 20, -1);
        check_frame("rx_er",      1, 60,   0,   1,  0,  0,  0);

        clear_stats(); build_frame(36, 5, 1);   send_frame(7, -1, -1);
        check_frame("runt_L40",   1, 36,   0,   1,  0,  1,  0);

        clear_stats(); build_frame(59, 9, 1);   send_frame(3, -1, -1);
        check_frame("runt_L63",   1, 59,   0,   1,  0,  1,  0);

        clear_stats(); build_frame(1, 17, 1);   send_frame(7, -1, -1);
        check_frame("short_L5",   1, 1,    0,   1,  0,  1,  0);

        clear_stats(); build_frame(1514, 1, 1); send_frame(7, -1, -1);
        check_frame("max_L1518",  1, 1514, 1,   0,  0,  0,  0);

        clear_stats(); build_frame(1515, 2, 1); send_frame(7, -1, -1);
        check_frame("over_L1519", 1, 1515, 0,   1,  0,  1,  0);

        // Two frames separated by a single dv-low cycle
        clear_stats();
        build_frame(60, 5, 1); send_frame(7, -1, -1);
        build_frame(60, 9, 1); send_frame(7, -1, -1);
        check_frame("b2b",        2, 120,  2,   0,  0,  0,  0);

        // Bad preamble byte
        clear_stats();
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'h5A);
        repeat (10) drive(1'b1, 1'b0, 8'h11);
        drive(1'b0, 1'b0, 8'h00);
        check_frame("pre_err",    1, 0,    0,   0,  0,  0,  1);

        clear_stats(); build_frame(0, 0, 0);    send_frame(7, -1, -1);
        check_frame("sfd_only",   1, 0,    0,   0,  0,  0,  1);

        clear_stats(); build_frame(3, 4, 0);    send_frame(7, -1, -1);
        check_frame("L3",         1, 0,    0,   0,  0,  0,  1);

        // Reset during byte 30, released while dv still high
        clear_stats();
        build_frame(60, 7, 1);
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < frm.size(); i++) begin
            drive(1'b1, 1'b0, frm[i]);
            if (i == 30) begin
                reset = 1'b1;
                #1 check("rst_mid.outs", outs_now(), 0);
            end
            if (i == 32) begin
                reset = 1'b0;
                clear_stats();
            end
        end
        drive(1'b0, 1'b0, 8'h00);
        check_frame("rst_abort",  1, 0,    0,   0,  0,  0,  0);

        clear_stats(); build_frame(60, 11, 1);  send_frame(7, -1, -1);
        check_frame("after_rst",  1, 60,   1,   0,  0,  0,  0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gmii_rx_framer.md
# gmii_rx_framer

Receive framer between the 1G GMII PHY pins and the RX MAC-to-AXI queue. It strips preamble, SFD and FCS and checks the CRC-32 and the frame length. It presents payload bytes as one contiguous `rx_data_valid` burst per frame, followed by exactly one `rx_good_frame` or `rx_bad_frame` pulse. Runs entirely in the clk125 domain.

## Interface
Parameters:
- `MIN_FRAME_LEN`, 64: minimum legal length in bytes, DA through FCS inclusive.
- `MAX_FRAME_LEN`, 1518: maximum legal length in bytes, DA through FCS inclusive.

Ports:
- `clk125`  in  1  GMII receive clock, 125 MHz.
- `reset`  in  1  Reset; asynchronous, active-high.
- `gmii_rxd`  in  8  GMII receive data.
- `gmii_rx_dv`  in  1  GMII data valid.
- `gmii_rx_er`  in  1  GMII receive error.
- `rx_data`  out  8  Payload byte.
- `rx_data_valid`  out  1  High for every payload byte of a frame, contiguously.
- `rx_good_frame`  out  1  1-cycle pulse: frame passed all checks.
- `rx_bad_frame`  out  1  1-cycle pulse: frame failed at least one check.
- `stat_crc_err`  out  1  1-cycle pulse, coincident with `rx_bad_frame`, on FCS mismatch.
- `stat_len_err`  out  1  1-cycle pulse, coincident with `rx_bad_frame`, on runt (L < MIN) or oversize (L > MAX).
- `stat_drop`  out  1  1-cycle pulse for a frame discarded silently: preamble/SFD error or L < 5.

Reset value of all outputs: 0.

## Operation
- Input stage registers `gmii_rxd`, `gmii_rx_dv` and `gmii_rx_er` once. All decisions are made on the registered values.
- **IDLE**
  - Rising edge of dv with byte 0x55 -> PREAMBLE.
  - Rising edge with any other byte -> DISCARD.
  - dv high with no rising edge (e.g. after reset release) -> DISCARD.
- **PREAMBLE**
  - 0x55 -> stay; the number of preamble bytes is not limited.
  - 0xD5 -> DATA. Clear the byte counter, set the CRC to 0xFFFFFFFF, clear the error flag.
  - Any other byte -> DISCARD with a `stat_drop` pulse.
  - dv low -> IDLE with a `stat_drop` pulse.
- **DATA**
  - Each byte updates the CRC (reflected IEEE 802.3 polynomial) and increments the 14-bit byte counter L, which saturates at 16383.
  - Each byte shifts into a 4-byte delay line. The byte leaving the line is emitted as payload only once the line was already full, so the last 4 bytes (the FCS) are never emitted.
  - `gmii_rx_er` high while dv is high sets the sticky error flag.
  - dv low -> evaluate the frame and go to IDLE.
- **Evaluation at end of DATA**
  - L < 5: no payload has been emitted. Pulse `stat_drop` only; no good or bad pulse.
  - Otherwise the frame is bad if any of these hold: CRC register ≠ residue 0xC704DD7B; error flag set; L < MIN_FRAME_LEN; L > MAX_FRAME_LEN.
  - Bad frame: pulse `rx_bad_frame` together with the matching `stat_*` pulse(s).
  - Good frame: pulse `rx_good_frame`.
- **DISCARD**
  - Wait for dv low -> IDLE. Nothing is emitted.
- `gmii_rx_er` while dv is low (false carrier or carrier extension) is ignored.
- There is no backpressure. The downstream queue drops frames itself.

## Timing
- Payload byte k (k = 0 is the first byte after the SFD) is on `rx_data` with `rx_data_valid`=1 exactly 6 clk125 cycles after it was on `gmii_rxd`.
- For a frame of L ≥ 5 bytes, `rx_data_valid` is high for exactly L−4 consecutive cycles.
- The status pulse occurs on the first cycle after the last payload byte. `rx_data_valid` is 0 in that cycle.
- A gap of 1 cycle with dv low between frames is sufficient. Back-to-back frames never overlap at the output.
- `rx_data` holds its last value when `rx_data_valid` is 0.
- Reset mid-frame:
  - All outputs go to 0 asynchronously, with no status pulse.
  - After reset is released, the remainder of the in-progress frame is discarded (the IDLE rule for dv high without a rising edge).

## Structure
- Shared package `gmii_pkg` holds:
  - constants `PREAMBLE_BYTE` = 8'h55, `SFD_BYTE` = 8'hD5, `CRC_INIT` = 32'hFFFFFFFF, `CRC_RESIDUE` = 32'hC704DD7B;
  - the framer state encoding.
- Sub-module `crc32_d8`: combinational next-CRC for 8-bit data (reflected 802.3). It is reusable by the TX path.

## Test plan
- 7×0x55, 0xD5, 60-byte payload, valid FCS (L=64) -> 60 valid cycles with the bytes in order, 6-cycle latency, then one `rx_good_frame` pulse.
- Same frame with one payload bit flipped -> 60 valid cycles, then `rx_bad_frame` and `stat_crc_err` pulsed together.
- `gmii_rx_er` high on byte 20 of a 64-byte frame with valid FCS -> `rx_bad_frame` only; `stat_crc_err` and `stat_len_err` stay 0.
- Runt with L=40 and valid FCS -> 36 valid cycles, then `rx_bad_frame` and `stat_len_err`. Oversize with L=1519 -> 1515 valid cycles, then `rx_bad_frame` and `stat_len_err`.
- Preamble 0x55,0x55,0x5A; SFD-only frame (L=0); and L=3 -> `stat_drop` each time, no `rx_data_valid`, no good or bad pulse.
- Reset asserted during byte 30 and released while dv is still high -> outputs 0, that frame discarded. The next normal frame, after a 12-cycle gap, yields `rx_good_frame`.
